// File: rtl/spi_ram_model_if.sv
// rtl/spi_ram_model_if.sv - single-lane mode-0 SPI pin bundle between the CPU and the serial-RAM model
interface spi_ram_model_if;
    logic spi_cs_n;
    logic spi_sck;
    logic spi_mosi;
    logic spi_miso;
    logic spi_miso_oe;

    modport master (
        output spi_cs_n,
        output spi_sck,
        output spi_mosi,
        input  spi_miso,
        input  spi_miso_oe
    );

    modport slave (
        input  spi_cs_n,
        input  spi_sck,
        input  spi_mosi,
        output spi_miso,
        output spi_miso_oe
    );
endinterface

// File: rtl/spi_ram_model.sv
// rtl/spi_ram_model.sv - SPI serial-RAM model backed by block RAM, all pins oversampled in clk
// Serves READ (0x03), WRITE (0x02) and RDSTATUS (0x05); other commands are ignored until cs_n rises.
module spi_ram_model #(
    parameter int          ADDR_BITS  = 12,
    parameter logic [7:0]  STATUS_VAL = 8'h00,
    parameter string       INIT_FILE  = ""
) (
    input  logic           clk,
    input  logic           reset,
    spi_ram_model_if.slave spi
);

    typedef enum logic [2:0] {
        WAIT_CS_HIGH,
        IDLE,
        CMD,
        ADDR,
        READ,
        WRITE,
        STATUS,
        IGNORE
    } state_t;

    state_t state;

    logic cs_meta, cs_sync, cs_prev;
    logic sck_meta, sck_sync, sck_prev;
    logic mosi_meta, mosi_sync;
    logic [1:0] sync_fill;

    logic cs_rise, cs_fall, sck_rise, sck_fall;

    logic [ADDR_BITS-2:0] rx_shift;
    logic [ADDR_BITS-1:0] rx_next;
    logic [4:0]           bit_cnt;
    logic                 cmd_read;
    logic [ADDR_BITS-1:0] addr;
    logic [7:0]           tx_shift;
    logic [7:0]           tx_src;
    logic                 miso_q;
    logic                 miso_oe_q;

    logic [ADDR_BITS-1:0] rd_addr;
    logic [7:0]           rd_data;
    logic                 wr_en;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [7:0]           wr_data;

    logic [7:0] mem [0:(1 << ADDR_BITS) - 1];

    // sync_fill keeps WAIT_CS_HIGH from trusting the reset value of the cs_n synchronizer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_meta   <= 1'b1;
            cs_sync   <= 1'b1;
            cs_prev   <= 1'b1;
            sck_meta  <= 1'b0;
            sck_sync  <= 1'b0;
            sck_prev  <= 1'b0;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
            sync_fill <= 2'd0;
        end else begin
            cs_meta   <= spi.spi_cs_n;
            cs_sync   <= cs_meta;
            cs_prev   <= cs_sync;
            sck_meta  <= spi.spi_sck;
            sck_sync  <= sck_meta;
            sck_prev  <= sck_sync;
            mosi_meta <= spi.spi_mosi;
            mosi_sync <= mosi_meta;
            if (sync_fill != 2'd3) begin
                sync_fill <= sync_fill + 2'd1;
            end
        end
    end

    assign cs_rise  =  cs_sync  & ~cs_prev;
    assign cs_fall  = ~cs_sync  &  cs_prev;
    assign sck_rise =  sck_sync & ~sck_prev;
    assign sck_fall = ~sck_sync &  sck_prev;

    // Only the low ADDR_BITS of the 24-bit address are kept; upper bits fall off the shifter.
    assign rx_next = {rx_shift, mosi_sync};
    assign tx_src  = (state == READ) ? rd_data : STATUS_VAL;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= WAIT_CS_HIGH;
            rx_shift  <= '0;
            bit_cnt   <= 5'd0;
            cmd_read  <= 1'b0;
            addr      <= '0;
            tx_shift  <= 8'h00;
            miso_q    <= 1'b0;
            miso_oe_q <= 1'b0;
            rd_addr   <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= 8'h00;
        end else begin
            wr_en <= 1'b0;
            if (state == WAIT_CS_HIGH) begin
                if (sync_fill == 2'd3 && cs_sync) begin
                    state <= IDLE;
                end
            end else if (cs_rise) begin
                state     <= IDLE;
                miso_oe_q <= 1'b0;
                miso_q    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cs_fall) begin
                            state    <= CMD;
                            bit_cnt  <= 5'd0;
                            rx_shift <= '0;
                        end
                    end
                    CMD: begin
                        if (sck_rise) begin
                            rx_shift <= rx_next[ADDR_BITS-2:0];
                            if (bit_cnt == 5'd7) begin
                                bit_cnt <= 5'd0;
                                case (rx_next[7:0])
                                    8'h03: begin state <= ADDR;   cmd_read <= 1'b1; end
                                    8'h02: begin state <= ADDR;   cmd_read <= 1'b0; end
                                    8'h05: state <= STATUS;
                                    default: state <= IGNORE;
                                endcase
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    ADDR: begin
                        if (sck_rise) begin
                            rx_shift <= rx_next[ADDR_BITS-2:0];
                            if (bit_cnt == 5'd23) begin
                                bit_cnt <= 5'd0;
                                addr    <= rx_next;
                                if (cmd_read) begin
                                    rd_addr <= rx_next;
                                    state   <= READ;
                                end else begin
                                    state <= WRITE;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    READ, STATUS: begin
                        if (sck_fall) begin
                            miso_oe_q <= 1'b1;
                            if (bit_cnt == 5'd0) begin
                                miso_q   <= tx_src[7];
                                tx_shift <= {tx_src[6:0], 1'b0};
                            end else begin
                                miso_q   <= tx_shift[7];
                                tx_shift <= {tx_shift[6:0], 1'b0};
                            end
                            // Bit 0 just went out: move on and prefetch the next byte.
                            if (bit_cnt == 5'd7) begin
                                bit_cnt <= 5'd0;
                                if (state == READ) begin
                                    addr    <= addr + 1'b1;
                                    rd_addr <= addr + 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    WRITE: begin
                        if (sck_rise) begin
                            rx_shift <= rx_next[ADDR_BITS-2:0];
                            if (bit_cnt == 5'd7) begin
                                bit_cnt <= 5'd0;
                                wr_en   <= 1'b1;
                                wr_addr <= addr;
                                wr_data <= rx_next[7:0];
                                addr    <= addr + 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

    assign spi.spi_miso    = miso_q;
    assign spi.spi_miso_oe = miso_oe_q;

endmodule

// File: tb/tb_spi_ram_model.sv
// tb/tb_spi_ram_model.sv - scoreboard bench driving mode-0 SPI transactions into spi_ram_model
module tb_spi_ram_model;

    logic clk = 1'b0;
    logic reset;

    spi_ram_model_if spi();

    spi_ram_model #(
        .ADDR_BITS  (12),
        .STATUS_VAL (8'h5A),
        .INIT_FILE  ("")
    ) dut (
        .clk   (clk),
        .reset (reset),
        .spi   (spi)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] model [0:4095];
    logic [7:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Master samples MISO just before each rising SCK and again just before the following fall.
    task automatic spi_bits(input logic [7:0] tx, input int nbits, input int half,
                            output logic [7:0] rx, output logic [7:0] rx_hi,
                            output logic oe_all, output logic oe_any);
        rx = 8'h00; rx_hi = 8'h00; oe_all = 1'b1; oe_any = 1'b0;
        for (int i = 7; i >= 8 - nbits; i--) begin
            spi.spi_mosi = tx[i];
            wait_clk(half);
            rx[i]  = spi.spi_miso;
            oe_all = oe_all & spi.spi_miso_oe;
            oe_any = oe_any | spi.spi_miso_oe;
            spi.spi_sck = 1'b1;
            wait_clk(half);
            rx_hi[i] = spi.spi_miso;
            oe_all   = oe_all & spi.spi_miso_oe;
            oe_any   = oe_any | spi.spi_miso_oe;
            spi.spi_sck = 1'b0;
        end
    endtask

    task automatic cs_begin(input int half);
        spi.spi_cs_n = 1'b0;
        wait_clk(half);
    endtask

    task automatic cs_end(input int half);
        wait_clk(half);
        spi.spi_cs_n = 1'b1;
        wait_clk(half + 4);
        check("cs_end_oe", 32'(spi.spi_miso_oe), 32'd0);
    endtask

    task automatic send_header(input logic [7:0] cmd, input logic [23:0] a, input int half,
                               output logic oe_any);
        logic [7:0] rx, rxh;
        logic       all1, any1;
        spi_bits(cmd, 8, half, rx, rxh, all1, any1);
        oe_any = any1;
        for (int b = 2; b >= 0; b--) begin
            spi_bits(a[b*8 +: 8], 8, half, rx, rxh, all1, any1);
            oe_any = oe_any | any1;
        end
    endtask

    task automatic take_bytes(input int n, input int half, input string tag);
        logic [7:0] rx, rxh, e;
        logic       all1, any1;
        for (int i = 0; i < n; i++) begin
            spi_bits(8'hFF, 8, half, rx, rxh, all1, any1);
            if (exp_q.size() == 0) begin
                check({tag, "_underflow"}, 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check({tag, "_data"}, 32'(rx), 32'(e));
                check({tag, "_stable"}, 32'(rxh), 32'(e));
                check({tag, "_oe"}, 32'(all1), 32'd1);
            end
        end
    endtask

    task automatic do_write(input logic [23:0] a, input logic [7:0] data [$], input int half);
        logic [7:0] rx, rxh;
        logic       all1, any1, hdr_any, oe_any;
        cs_begin(half);
        send_header(8'h02, a, half, hdr_any);
        oe_any = hdr_any;
        foreach (data[i]) begin
            spi_bits(data[i], 8, half, rx, rxh, all1, any1);
            oe_any = oe_any | any1;
            model[12'(a + 24'(i))] = data[i];
        end
        cs_end(half);
        check("wr_oe", 32'(oe_any), 32'd0);
    endtask

    task automatic do_read(input logic [23:0] a, input int n, input int half);
        logic hdr_any;
        for (int i = 0; i < n; i++) exp_q.push_back(model[12'(a + 24'(i))]);
        cs_begin(half);
        send_header(8'h03, a, half, hdr_any);
        check("rd_hdr_oe", 32'(hdr_any), 32'd0);
        take_bytes(n, half, "rd");
        cs_end(half);
    endtask

    initial begin
        logic [7:0] rx, rxh;
        logic       all1, any1, hdr_any;

        reset        = 1'b1;
        spi.spi_cs_n = 1'b1;
        spi.spi_sck  = 1'b0;
        spi.spi_mosi = 1'b0;
        wait_clk(5);
        check("rst_miso", 32'(spi.spi_miso), 32'd0);
        check("rst_oe", 32'(spi.spi_miso_oe), 32'd0);
        reset = 1'b0;
        wait_clk(6);
        check("post_rst_miso", 32'(spi.spi_miso), 32'd0);
        check("post_rst_oe", 32'(spi.spi_miso_oe), 32'd0);

        // Single byte, read back with junk in the ignored upper address bits.
        do_write(24'h000010, '{8'hA5}, 6);
        do_read(24'hAB0010, 1, 6);

        // Burst across the top of the 4 KiB space.
        do_write(24'h000FFE, '{8'h11, 8'h22, 8'h33, 8'h44}, 6);
        do_read(24'h000FFE, 4, 6);
        exp_q.push_back(8'h33);
        cs_begin(6);
        send_header(8'h03, 24'h000000, 6, hdr_any);
        take_bytes(1, 6, "wrap");
        cs_end(6);

        // Partial write byte is dropped.
        do_write(24'h000020, '{8'h3C}, 6);
        cs_begin(6);
        send_header(8'h02, 24'h000020, 6, hdr_any);
        spi_bits(8'hC3, 5, 6, rx, rxh, all1, any1);
        cs_end(6);
        do_read(24'h000020, 1, 6);

        // Status repeats every byte.
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h5A);
        cs_begin(6);
        spi_bits(8'h05, 8, 6, rx, rxh, all1, any1);
        check("st_cmd_oe", 32'(any1), 32'd0);
        take_bytes(2, 6, "st");
        cs_end(6);

        // Unknown command keeps MISO released for the whole transaction.
        cs_begin(6);
        send_header(8'hFF, 24'h000010, 6, hdr_any);
        spi_bits(8'h00, 8, 6, rx, rxh, all1, any1);
        check("ign_oe", 32'(hdr_any | any1), 32'd0);
        cs_end(6);
        do_read(24'h000010, 1, 6);

        // Reset in the middle of a read; SCK traffic before cs_n rises must not decode as a write.
        exp_q.push_back(model[12'h010]);
        cs_begin(6);
        send_header(8'h03, 24'h000010, 6, hdr_any);
        take_bytes(1, 6, "pre_rst");
        reset = 1'b1;
        #1;
        check("midrst_oe", 32'(spi.spi_miso_oe), 32'd0);
        check("midrst_miso", 32'(spi.spi_miso), 32'd0);
        wait_clk(3);
        reset = 1'b0;
        wait_clk(6);
        send_header(8'h02, 24'h000020, 6, hdr_any);
        spi_bits(8'h77, 8, 6, rx, rxh, all1, any1);
        check("after_rst_oe", 32'(hdr_any | any1), 32'd0);
        cs_end(6);
        do_read(24'h000020, 1, 6);

        // Minimum versus long SCK phase.
        do_write(24'h000100, '{8'hDE, 8'hAD, 8'hBE, 8'hEF}, 6);
        do_read(24'h000100, 4, 6);
        do_read(24'h000100, 4, 50);
        do_write(24'h000200, '{8'h5C, 8'h81}, 50);
        do_read(24'h000200, 2, 6);

        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
